// File: rtl/bus_dma.sv
// Bus-initiator DMA: copies a block of 32-bit words from src to dst over the
// shared CPU bus, one read cycle then one write cycle per word, gated by bus_grant.
module bus_dma #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LEN_W-1:0] words_done,
    output logic             bus_req,
    input  logic             bus_grant,
    output logic [31:0]      bus_addr,
    output logic             bus_wen,
    output logic [31:0]      bus_wdata,
    input  logic [31:0]      bus_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
    } bus_cyc_t;

    state_t           state, state_nx;
    bus_cyc_t         cyc;
    logic [31:0]      cur_src, cur_dst, data_q;
    logic [LEN_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    // abort outranks grant: no cycle is driven and the FSM heads straight to DONE
    always_comb begin
        state_nx = state;
        cyc      = '0;
        case (state)
            IDLE: begin
                if (start) state_nx = (len != '0) ? READ : DONE;
            end
            READ: begin
                if (abort) begin
                    state_nx = DONE;
                end else if (bus_grant) begin
                    cyc.addr = cur_src;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_nx = DONE;
                end else if (bus_grant) begin
                    cyc.addr  = cur_dst;
                    cyc.wen   = 1'b1;
                    cyc.wdata = data_q;
                    state_nx  = (remaining == LEN_W'(1)) ? DONE : READ;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cur_src    <= '0;
            cur_dst    <= '0;
            remaining  <= '0;
            data_q     <= '0;
            words_done <= '0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        words_done <= '0;
                        aborted    <= 1'b0;
                        if (len != '0) begin
                            cur_src   <= src_addr & ~32'h3;
                            cur_dst   <= dst_addr & ~32'h3;
                            remaining <= len;
                        end
                    end
                end
                READ: begin
                    if (abort)          aborted <= 1'b1;
                    else if (bus_grant) data_q  <= bus_rdata;
                end
                WRITE: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (bus_grant) begin
                        words_done <= words_done + LEN_W'(1);
                        remaining  <= remaining - LEN_W'(1);
                        cur_src    <= cur_src + 32'd4;
                        cur_dst    <= cur_dst + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == READ) || (state == WRITE);
    assign bus_req   = busy;
    assign done      = (state == DONE);
    assign bus_addr  = cyc.addr;
    assign bus_wen   = cyc.wen;
    assign bus_wdata = cyc.wdata;

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: word-addressed memory model on the bus plus a
// negedge monitor that logs bus cycles and flags protocol violations.
module tb_bus_dma;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_i, start, abort, bus_grant;
    logic [31:0]      src_addr, dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy, done, aborted, bus_req, bus_wen;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      bus_addr, bus_wdata, bus_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] wr_a[$], wr_d[$], rd_a[$];
    int busy_cnt, done_cnt, bad_cnt;
    int n_tests = 0, n_fail = 0;

    bus_dma #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_i(rst_i), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .abort(abort), .busy(busy),
        .done(done), .aborted(aborted), .words_done(words_done),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_addr(bus_addr),
        .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    assign bus_rdata = mem[bus_addr[11:2]];

    always @(negedge clk) begin
        busy_cnt = busy_cnt + int'(busy);
        done_cnt = done_cnt + int'(done);
        if (bus_req !== busy) bad_cnt = bad_cnt + 1;
        if (!bus_grant && (bus_wen || bus_addr != 0 || bus_wdata != 0)) bad_cnt = bad_cnt + 1;
        if (bus_wen) begin
            wr_a.push_back(bus_addr);
            wr_d.push_back(bus_wdata);
            mem[bus_addr[11:2]] = bus_wdata;
        end else if (bus_req && bus_grant && !abort) begin
            rd_a.push_back(bus_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk); #1;
        busy_cnt = 0; done_cnt = 0; bad_cnt = 0;
        wr_a.delete(); wr_d.delete(); rd_a.delete();
    endtask

    // leaves the bench 1 time unit after the edge that latched the command
    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_timeout"}, 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] sched;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[32'h100 >> 2] = 32'hAAAA0001;
        mem[32'h104 >> 2] = 32'hBBBB0002;
        mem[32'h108 >> 2] = 32'hCCCC0003;
        mem[32'h10C >> 2] = 32'hDDDD0004;
        mem[32'h110 >> 2] = 32'hEEEE0005;
        mem[1023]         = 32'h11111111;
        mem[0]            = 32'h22222222;
        rst_i = 1'b1; start = 1'b0; abort = 1'b0; bus_grant = 1'b1;
        src_addr = '0; dst_addr = '0; len = '0;
        repeat (2) @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_words", 32'(words_done), 0);
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_bus", {bus_addr ^ bus_wdata, 31'(0), bus_wen} == 0 ? 32'd0 : 32'd1, 0);

        // basic 4-word copy
        clr_mon();
        pulse_start(32'h100, 32'h200, 4);
        wait_done("basic", 40);
        chk("basic_busy", busy_cnt, 8);
        chk("basic_done", done_cnt, 1);
        chk("basic_nwr", wr_a.size(), 4);
        chk("basic_a0", wr_a[0], 32'h200);
        chk("basic_d0", wr_d[0], 32'hAAAA0001);
        chk("basic_a3", wr_a[3], 32'h20C);
        chk("basic_d3", wr_d[3], 32'hDDDD0004);
        chk("basic_m2", mem[32'h208 >> 2], 32'hCCCC0003);
        chk("basic_words", 32'(words_done), 4);
        chk("basic_aborted", 32'(aborted), 0);
        chk("basic_bad", bad_cnt, 0);

        // zero length: done on the cycle after start, no bus traffic
        clr_mon();
        @(posedge clk); #1;
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h800; len = 0;
        @(negedge clk);
        chk("zero_done_early", 32'(done), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("zero_done", 32'(done), 1);
        repeat (3) @(negedge clk);
        chk("zero_busy", busy_cnt, 0);
        chk("zero_nwr", wr_a.size() + rd_a.size(), 0);
        chk("zero_words", 32'(words_done), 0);
        chk("zero_ndone", done_cnt, 1);

        // grant stalls: 3 low cycles in READ, 2 in WRITE on the first word
        sched = 9'b111001000;
        clr_mon();
        bus_grant = 1'b0;
        pulse_start(32'h100, 32'h300, 2);
        for (int i = 1; i < 9; i++) begin
            @(posedge clk); #1;
            bus_grant = sched[i];
        end
        wait_done("stall", 20);
        bus_grant = 1'b1;
        chk("stall_busy", busy_cnt, 9);
        chk("stall_bad", bad_cnt, 0);
        chk("stall_nwr", wr_a.size(), 2);
        chk("stall_d0", wr_d[0], 32'hAAAA0001);
        chk("stall_a1", wr_a[1], 32'h304);
        chk("stall_d1", wr_d[1], 32'hBBBB0002);
        chk("stall_r1", rd_a[1], 32'h104);

        // abort during the second WRITE cycle
        mem[32'h400 >> 2] = 32'h5E5E0000;
        mem[32'h404 >> 2] = 32'h5E5E0001;
        clr_mon();
        pulse_start(32'h100, 32'h400, 5);
        repeat (2) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_wen", 32'(bus_wen), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_done", 32'(done), 1);
        repeat (3) @(negedge clk);
        chk("abort_flag", 32'(aborted), 1);
        chk("abort_words", 32'(words_done), 1);
        chk("abort_nwr", wr_a.size(), 1);
        chk("abort_m0", mem[32'h400 >> 2], 32'hAAAA0001);
        chk("abort_m1", mem[32'h404 >> 2], 32'h5E5E0001);

        // reset in a WRITE cycle abandons the transfer
        clr_mon();
        pulse_start(32'h100, 32'h500, 3);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        chk("rstw_inwrite", 32'(bus_wen), 1);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("rstw_busy", 32'(busy | bus_req | bus_wen | done), 0);
        chk("rstw_addr", bus_addr | bus_wdata, 0);
        chk("rstw_words", 32'(words_done), 0);
        chk("rstw_aborted", 32'(aborted), 0);
        repeat (4) @(negedge clk);
        chk("rstw_nodone", done_cnt, 0);

        // unaligned addresses and 32-bit wrap of the source
        clr_mon();
        pulse_start(32'hFFFFFFFE, 32'h13, 2);
        wait_done("align", 20);
        chk("align_nrd", rd_a.size(), 2);
        chk("align_r0", rd_a[0], 32'hFFFFFFFC);
        chk("align_r1", rd_a[1], 32'h0);
        chk("align_a0", wr_a[0], 32'h10);
        chk("align_a1", wr_a[1], 32'h14);
        chk("align_d1", wr_d[1], 32'h22222222);

        // start while busy is ignored
        clr_mon();
        pulse_start(32'h100, 32'h600, 2);
        @(posedge clk); #1;
        start = 1'b1; src_addr = 32'h10C; dst_addr = 32'h700; len = 7;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ign", 20);
        chk("ign_busy", busy_cnt, 4);
        chk("ign_nwr", wr_a.size(), 2);
        chk("ign_a1", wr_a[1], 32'h604);
        chk("ign_d1", wr_d[1], 32'hBBBB0002);
        chk("ign_words", 32'(words_done), 2);
        chk("ign_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
